hack_alu_sequencer: RTL and testbench
=====================================

// Module: hack_alu_sequencer
// PURPOSE
//  Multi-cycle Hack instruction sequencer. Owns the A, D and PC registers and fetches from instruction memory.
//  Drives the combinational Hack ALU (x, y, zx/nx/zy/ny/f/no) and evaluates jumps from zr/ng.
//  Sequences data-memory reads and writes over a req/ready handshake. Sits between ROM, RAM and the ALU as the CPU core.
// PARAMETERS
//  ADDR_W  15  instruction and data address width; PC width
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  imem_req     out  1       instruction fetch request
//  imem_addr    out  ADDR_W  fetch address (= pc)
//  imem_valid   in   1       imem_data valid; completes the fetch
//  imem_data    in   16      instruction word
//  dmem_req     out  1       data access request
//  dmem_we      out  1       1 = write, 0 = read; valid with dmem_req
//  dmem_addr    out  ADDR_W  data address
//  dmem_wdata   out  16      write data
//  dmem_rdata   in   16      read data; sampled when dmem_ready is high
//  dmem_ready   in   1       completes a data access
//  alu_x        out  16      ALU x operand (D)
//  alu_y        out  16      ALU y operand (A or M)
//  alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out 1 each  = IR[11:6], in that order
//  alu_out      in   16      ALU result
//  alu_zr       in   1       ALU zero flag
//  alu_ng       in   1       ALU negative flag
//  pc           out  ADDR_W  current program counter
//  retired      out  1       one-cycle pulse per completed instruction
//  trap         out  1       illegal-instruction trap, sticky; tied 0 without HACK_CTRL_TRAP_EN
// BEHAVIOUR
//  Reset: all outputs 0; pc = 0, A = 0, D = 0, IR = 0; state = BOOT. Reset wins over every event, including mid-access.
//    Requests drop on the edge that samples reset. No write is performed for an interrupted WRITE_M.
//  States:
//    BOOT -> FETCH, unconditional.
//    FETCH: imem_req = 1, imem_addr = pc. Both are held stable until imem_valid, which may arrive in the same cycle.
//      On imem_valid: IR <= imem_data, go to DECODE.
//    DECODE, IR[15] = 0 (A-instruction): A <= IR; pc <= pc + 1; retired pulse; go to FETCH.
//    DECODE, IR[15] = 1 (C-instruction): if IR[12] = 1 go to READ_M, else go to EXEC.
//    READ_M: dmem_req = 1, dmem_we = 0, dmem_addr = A[ADDR_W-1:0], held until dmem_ready.
//      On dmem_ready: Mop <= dmem_rdata, go to EXEC.
//    EXEC: alu_x = D; alu_y = IR[12] ? Mop : A; ALU control = IR[11:6]. Result, zr and ng are sampled on this edge.
//      Latch R = alu_out. Latch oldA = A. If IR[4]: D <= R. If IR[5]: A <= R.
//      jmp = (IR[2] & ng) | (IR[1] & zr) | (IR[0] & ~ng & ~zr).
//      If IR[3]: go to WRITE_M. Otherwise pc update, retired pulse, go to FETCH.
//    WRITE_M: dmem_req = 1, dmem_we = 1, dmem_addr = oldA[ADDR_W-1:0], dmem_wdata = R, held until dmem_ready.
//      On dmem_ready: pc update, retired pulse, go to FETCH.
//  pc update: pc <= jmp ? oldA[ADDR_W-1:0] : pc + 1. The jump target and the write address always use A from before the instruction.
//  pc + 1 wraps from 2^ADDR_W - 1 to 0.
//  Outside EXEC, ALU outputs are 0. Outside their own states, dmem_* and imem_* outputs are 0. Requests are never withdrawn before completion.
//  Latency with zero-wait memories:
//    A-instruction: 2 cycles (FETCH, DECODE).
//    C-instruction: 3 cycles; +1 for a read of M; +1 for a write of M.
//  All arithmetic is 16-bit and wraps; A and D are full 16 bits.
// CONFIGURATION
//  HACK_CTRL_TRAP_EN defined: a C-instruction with IR[14:13] != 2'b11 sends DECODE to TRAP.
//    TRAP: trap = 1; no register or memory writes; no retire; no fetch. Stays in TRAP until reset.
//  HACK_CTRL_TRAP_EN undefined: IR[14:13] are ignored, there is no TRAP state, and trap = 0.
// STRUCTURE
//  hack_pkg: state encodings (BOOT, FETCH, DECODE, READ_M, EXEC, WRITE_M, TRAP); IR field positions (A/C bit, a, comp, dest, jump); ILLEGAL_MASK.
//  Sub-module hack_jump_eval: combinational; inputs jump[2:0], zr, ng; output jmp.
//  The ALU is external and not instantiated here.
// TESTING
//  1. ROM {0x0005, 0xEC10}, zero-wait -> after 2nd retired: A = 5, D = 5, pc = 2; cycle count 5 after BOOT.
//  2. @100, D = 5, then 0xE7C8 (M=D+1) -> exactly one dmem write pulse: addr 100, wdata 6, we = 1; pc advances by 1.
//  3. @10 then 0xEA87 (0;JMP) -> pc = 10; next imem_addr = 10; A and D unchanged.
//  4. D=M with dmem_ready delayed 3 cycles -> dmem_req/addr stable for 4 cycles, no retired until ready, then D = rdata.
//  5. Reset asserted in READ_M -> next cycle all requests 0, pc = A = D = 0; first fetch from 0 after BOOT.
//  6. 0x8000 -> with HACK_CTRL_TRAP_EN: trap = 1, no retired, imem_req stays 0. Without it: no writes, pc + 1, retired.

Source files
------------

// File: rtl/hack_alu_sequencer_pkg.sv
// Shared definitions for the Hack sequencer: FSM state encoding, instruction field positions
// and the illegal-instruction check used when HACK_CTRL_TRAP_EN is defined.
package hack_alu_sequencer_pkg;

    typedef enum logic [2:0] {
        S_BOOT    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_READ_M  = 3'd3,
        S_EXEC    = 3'd4,
        S_WRITE_M = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    localparam int IR_CI      = 15;
    localparam int IR_A       = 12;
    localparam int IR_COMP_HI = 11;
    localparam int IR_COMP_LO = 6;
    localparam int IR_DEST_A  = 5;
    localparam int IR_DEST_D  = 4;
    localparam int IR_DEST_M  = 3;
    localparam int IR_JUMP_HI = 2;
    localparam int IR_JUMP_LO = 0;

    // Both bits must be set in a well-formed C-instruction.
    localparam logic [15:0] ILLEGAL_MASK = 16'h6000;

    function automatic logic is_illegal(input logic [15:0] ir);
        return ir[IR_CI] && ((ir & ILLEGAL_MASK) != ILLEGAL_MASK);
    endfunction

endpackage

// File: rtl/hack_alu_sequencer_if.sv
// Bus bundle between the Hack sequencer and its instruction memory, data memory and ALU.
// master = sequencer side, slave = memories/ALU side.
interface hack_alu_sequencer_if #(
    parameter int ADDR_W = 15
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [15:0]       imem_data;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [15:0]       dmem_wdata;
    logic [15:0]       dmem_rdata;
    logic              dmem_ready;

    logic [15:0]       alu_x;
    logic [15:0]       alu_y;
    logic              alu_zx;
    logic              alu_nx;
    logic              alu_zy;
    logic              alu_ny;
    logic              alu_f;
    logic              alu_no;
    logic [15:0]       alu_out;
    logic              alu_zr;
    logic              alu_ng;

    logic [ADDR_W-1:0] pc;
    logic              retired;
    logic              trap;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_data,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready,
        output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        input  alu_out, alu_zr, alu_ng,
        output pc, retired, trap
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_data,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready,
        input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        output alu_out, alu_zr, alu_ng,
        input  pc, retired, trap
    );

endinterface

// File: rtl/hack_alu_sequencer_jump_eval.sv
// Hack jump condition: selects among less-than, equal and greater-than from the ALU flags.
module hack_alu_sequencer_jump_eval (
    input  logic [2:0] jump,
    input  logic       zr,
    input  logic       ng,
    output logic       jmp
);

    assign jmp = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_alu_sequencer.sv
// Multi-cycle Hack CPU core: owns A, D, PC and IR, sequences fetch / decode / memory / execute.
// Optional illegal-instruction trap is enabled by defining HACK_CTRL_TRAP_EN.
module hack_alu_sequencer
    import hack_alu_sequencer_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    hack_alu_sequencer_if.master  bus
);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       a_q;
    logic [15:0]       d_q;
    logic [15:0]       ir_q;
    logic [ADDR_W-1:0] tgt_q;

    logic              imem_req_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic              dmem_req_q;
    logic              dmem_we_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [15:0]       dmem_wdata_q;
    logic [15:0]       alu_x_q;
    logic [15:0]       alu_y_q;
    logic [5:0]        alu_ctrl_q;
    logic              retired_q;

    logic              jmp;
    logic [ADDR_W-1:0] pc_inc_d;
    logic [ADDR_W-1:0] exec_pc_d;

    hack_alu_sequencer_jump_eval u_jump_eval (
        .jump (ir_q[IR_JUMP_HI:IR_JUMP_LO]),
        .zr   (bus.alu_zr),
        .ng   (bus.alu_ng),
        .jmp  (jmp)
    );

    // A is still the pre-instruction value during EXEC, so it is the jump target here.
    assign pc_inc_d  = pc_q + ADDR_W'(1);
    assign exec_pc_d = jmp ? a_q[ADDR_W-1:0] : pc_inc_d;

`ifdef HACK_CTRL_TRAP_EN
    logic trap_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_BOOT;
            pc_q         <= '0;
            a_q          <= '0;
            d_q          <= '0;
            ir_q         <= '0;
            tgt_q        <= '0;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            alu_x_q      <= '0;
            alu_y_q      <= '0;
            alu_ctrl_q   <= '0;
            retired_q    <= 1'b0;
`ifdef HACK_CTRL_TRAP_EN
            trap_q       <= 1'b0;
`endif
        end else begin
            retired_q <= 1'b0;
            unique case (state_q)
                S_BOOT: begin
                    imem_req_q  <= 1'b1;
                    imem_addr_q <= pc_q;
                    state_q     <= S_FETCH;
                end

                S_FETCH: begin
                    if (bus.imem_valid) begin
                        ir_q        <= bus.imem_data;
                        imem_req_q  <= 1'b0;
                        imem_addr_q <= '0;
                        state_q     <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (!ir_q[IR_CI]) begin
                        a_q         <= ir_q;
                        pc_q        <= pc_inc_d;
                        retired_q   <= 1'b1;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_inc_d;
                        state_q     <= S_FETCH;
                    end
`ifdef HACK_CTRL_TRAP_EN
                    else if (is_illegal(ir_q)) begin
                        trap_q  <= 1'b1;
                        state_q <= S_TRAP;
                    end
`endif
                    else if (ir_q[IR_A]) begin
                        dmem_req_q  <= 1'b1;
                        dmem_we_q   <= 1'b0;
                        dmem_addr_q <= a_q[ADDR_W-1:0];
                        state_q     <= S_READ_M;
                    end else begin
                        alu_x_q    <= d_q;
                        alu_y_q    <= a_q;
                        alu_ctrl_q <= ir_q[IR_COMP_HI:IR_COMP_LO];
                        state_q    <= S_EXEC;
                    end
                end

                // The read data is held as the ALU y operand for the whole EXEC cycle.
                S_READ_M: begin
                    if (bus.dmem_ready) begin
                        dmem_req_q  <= 1'b0;
                        dmem_addr_q <= '0;
                        alu_x_q     <= d_q;
                        alu_y_q     <= bus.dmem_rdata;
                        alu_ctrl_q  <= ir_q[IR_COMP_HI:IR_COMP_LO];
                        state_q     <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    alu_x_q    <= '0;
                    alu_y_q    <= '0;
                    alu_ctrl_q <= '0;
                    if (ir_q[IR_DEST_D]) d_q <= bus.alu_out;
                    if (ir_q[IR_DEST_A]) a_q <= bus.alu_out;
                    if (ir_q[IR_DEST_M]) begin
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= 1'b1;
                        dmem_addr_q  <= a_q[ADDR_W-1:0];
                        dmem_wdata_q <= bus.alu_out;
                        tgt_q        <= exec_pc_d;
                        state_q      <= S_WRITE_M;
                    end else begin
                        pc_q        <= exec_pc_d;
                        retired_q   <= 1'b1;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= exec_pc_d;
                        state_q     <= S_FETCH;
                    end
                end

                S_WRITE_M: begin
                    if (bus.dmem_ready) begin
                        dmem_req_q   <= 1'b0;
                        dmem_we_q    <= 1'b0;
                        dmem_addr_q  <= '0;
                        dmem_wdata_q <= '0;
                        pc_q         <= tgt_q;
                        retired_q    <= 1'b1;
                        imem_req_q   <= 1'b1;
                        imem_addr_q  <= tgt_q;
                        state_q      <= S_FETCH;
                    end
                end

`ifdef HACK_CTRL_TRAP_EN
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
`endif

                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.alu_x      = alu_x_q;
    assign bus.alu_y      = alu_y_q;
    assign bus.alu_zx     = alu_ctrl_q[5];
    assign bus.alu_nx     = alu_ctrl_q[4];
    assign bus.alu_zy     = alu_ctrl_q[3];
    assign bus.alu_ny     = alu_ctrl_q[2];
    assign bus.alu_f      = alu_ctrl_q[1];
    assign bus.alu_no     = alu_ctrl_q[0];
    assign bus.pc         = pc_q;
    assign bus.retired    = retired_q;

`ifdef HACK_CTRL_TRAP_EN
    assign bus.trap = trap_q;
`else
    assign bus.trap = 1'b0;
`endif

endmodule

// File: tb/tb_hack_alu_sequencer.sv
// Bench for hack_alu_sequencer: behavioural ROM/RAM/ALU around the core, vector table plus
// hand-written sequences for wait states, reset mid-access, pc wrap and the trap option.
module tb_hack_alu_sequencer;

    localparam int          ADDR_W = 15;
    localparam logic [15:0] PROBE  = 16'hE040;   // comp "no" only: exposes D on x and A on y
    localparam logic [15:0] D_EQ_A = 16'hEC10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hack_alu_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    hack_alu_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0]       rom [0:255];
    logic [15:0]       mval;
    int                dwait;
    int                wcnt;
    int                ret_cnt;
    int                wr_cnt;
    logic [ADDR_W-1:0] last_waddr;
    logic [15:0]       last_wdata;
    int                checks = 0;
    int                errors = 0;

    assign bus.imem_valid = bus.imem_req;
    assign bus.imem_data  = rom[bus.imem_addr[7:0]];
    assign bus.dmem_ready = bus.dmem_req && (wcnt >= dwait);
    assign bus.dmem_rdata = mval;

    logic [15:0] ax, ay, ao;
    always_comb begin
        ax = bus.alu_zx ? 16'h0000 : bus.alu_x;
        if (bus.alu_nx) ax = ~ax;
        ay = bus.alu_zy ? 16'h0000 : bus.alu_y;
        if (bus.alu_ny) ay = ~ay;
        ao = bus.alu_f ? (ax + ay) : (ax & ay);
        if (bus.alu_no) ao = ~ao;
    end
    assign bus.alu_out = ao;
    assign bus.alu_zr  = (ao == 16'h0000);
    assign bus.alu_ng  = ao[15];

    always @(posedge clk) begin
        if (reset) begin
            wcnt    <= 0;
            ret_cnt <= 0;
            wr_cnt  <= 0;
        end else begin
            if (bus.dmem_req && !bus.dmem_ready) wcnt <= wcnt + 1;
            else                                 wcnt <= 0;
            if (bus.retired) ret_cnt <= ret_cnt + 1;
            if (bus.dmem_req && bus.dmem_we && bus.dmem_ready) begin
                wr_cnt     <= wr_cnt + 1;
                last_waddr <= bus.dmem_addr;
                last_wdata <= bus.dmem_wdata;
            end
        end
    end

    typedef struct {
        string             name;
        logic [15:0]       dval;
        logic [15:0]       aval;
        logic [15:0]       mval;
        logic [15:0]       instr;
        logic [15:0]       exp_d;
        logic [15:0]       exp_a;
        logic [ADDR_W-1:0] exp_pc;
        int                exp_wr;
        logic [ADDR_W-1:0] exp_waddr;
        logic [15:0]       exp_wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_retires(input int n, input string name);
        int t = 0;
        while (ret_cnt < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (ret_cnt < n) chk({name, " retire timeout"}, ret_cnt, n);
    endtask

    task automatic wait_probe(input string name);
        int t = 0;
        while (!bus.alu_no && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.alu_no) chk({name, " probe timeout"}, bus.alu_no, 1);
    endtask

    task automatic wait_dreq(input string name);
        int t = 0;
        while (!bus.dmem_req && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({name, " dmem_req seen"}, bus.dmem_req, 1);
    endtask

    task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < 256; i++) rom[i] = PROBE;
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    task automatic restart();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        reset = 1'b1;
        load_prog(v.dval, D_EQ_A, v.aval, v.instr);
        mval  = v.mval;
        dwait = 0;
        restart();
        wait_retires(4, v.name);
        chk({v.name, " pc"}, 32'(bus.pc), 32'(v.exp_pc));
        chk({v.name, " writes"}, wr_cnt, v.exp_wr);
        if (v.exp_wr != 0) begin
            chk({v.name, " waddr"}, 32'(last_waddr), 32'(v.exp_waddr));
            chk({v.name, " wdata"}, 32'(last_wdata), 32'(v.exp_wdata));
        end
        wait_probe(v.name);
        chk({v.name, " D"}, 32'(bus.alu_x), 32'(v.exp_d));
        chk({v.name, " A"}, 32'(bus.alu_y), 32'(v.exp_a));
    endtask

    initial begin
        int cyc;
        int n;
        int rcnt;
        logic stable;

        //            name         D        A        M        instr    expD     expA     pc       wr waddr wdata
        vecs.push_back('{"MeqDp1", 16'd5,   16'd100, 16'd0,   16'hE7C8, 16'd5,   16'd100, 15'd4,  1, 15'd100, 16'd6});
        vecs.push_back('{"JMP",    16'd3,   16'd10,  16'd0,   16'hEA87, 16'd3,   16'd10,  15'd10, 0, 15'd0,   16'd0});
        vecs.push_back('{"DeqM",   16'd7,   16'd20,  16'h1234,16'hFC10, 16'h1234,16'd20,  15'd4,  0, 15'd0,   16'd0});
        vecs.push_back('{"ADplus", 16'd9,   16'd30,  16'd0,   16'hE0B0, 16'd39,  16'd39,  15'd4,  0, 15'd0,   16'd0});
        vecs.push_back('{"JLTtkn", 16'd5,   16'd12,  16'd0,   16'hE4C4, 16'd5,   16'd12,  15'd12, 0, 15'd0,   16'd0});
        vecs.push_back('{"JGTnot", 16'd5,   16'd12,  16'd0,   16'hE4C1, 16'd5,   16'd12,  15'd4,  0, 15'd0,   16'd0});
        vecs.push_back('{"JEQtkn", 16'd0,   16'd16,  16'd0,   16'hE302, 16'd0,   16'd16,  15'd16, 0, 15'd0,   16'd0});
        vecs.push_back('{"AMjne",  16'd1,   16'd40,  16'd50,  16'hFCAD, 16'd1,   16'd49,  15'd40, 1, 15'd40,  16'd49});
        vecs.push_back('{"Dwrap",  16'h7FFF,16'd1,   16'd0,   16'hE7D0, 16'h8000,16'd1,   15'd4,  0, 15'd0,   16'd0});
        vecs.push_back('{"Dneg1",  16'd4,   16'd2,   16'd0,   16'hEE90, 16'hFFFF,16'd2,   15'd4,  0, 15'd0,   16'd0});
`ifndef HACK_CTRL_TRAP_EN
        vecs.push_back('{"ill8000",16'd3,   16'd9,   16'd0,   16'h8000, 16'd3,   16'd9,   15'd4,  0, 15'd0,   16'd0});
`endif

        // Outputs while reset is held
        reset = 1'b1;
        dwait = 0;
        mval  = '0;
        load_prog(PROBE, PROBE, PROBE, PROBE);
        repeat (3) @(negedge clk);
        chk("rst imem_req", bus.imem_req, 0);
        chk("rst dmem_req", bus.dmem_req, 0);
        chk("rst pc", 32'(bus.pc), 0);
        chk("rst retired_trap", {bus.retired, bus.trap}, 0);
        chk("rst alu_x", 32'(bus.alu_x), 0);

        // A-instruction then D=A with zero-wait memories: 5 cycles from the first fetch
        reset = 1'b1;
        load_prog(16'h0005, D_EQ_A, PROBE, PROBE);
        restart();
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t1 first fetch addr", 32'(bus.imem_addr), 0);
        cyc = 0;
        n   = 0;
        while (cyc < 50) begin
            if (bus.retired) n++;
            if (n == 2) break;
            cyc++;
            @(negedge clk);
        end
        chk("t1 cycles", cyc, 5);
        chk("t1 pc", 32'(bus.pc), 2);
        wait_probe("t1");
        chk("t1 D", 32'(bus.alu_x), 5);
        chk("t1 A", 32'(bus.alu_y), 5);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Slow read: request held until ready, no retire meanwhile
        reset = 1'b1;
        load_prog(16'd7, D_EQ_A, 16'd20, 16'hFC10);
        mval  = 16'hBEEF;
        dwait = 3;
        restart();
        wait_dreq("t4");
        stable = 1'b1;
        rcnt   = ret_cnt;
        for (int i = 0; i < 4; i++) begin
            if (!bus.dmem_req || bus.dmem_we || bus.dmem_addr != 15'd20 || bus.retired) stable = 1'b0;
            @(negedge clk);
        end
        chk("t4 held 4 cycles", stable, 1);
        chk("t4 no retire in wait", ret_cnt, rcnt);
        chk("t4 req released", bus.dmem_req, 0);
        wait_retires(4, "t4");
        wait_probe("t4");
        chk("t4 D", 32'(bus.alu_x), 32'h0000BEEF);
        chk("t4 A", 32'(bus.alu_y), 20);

        // Reset while a read is outstanding
        reset = 1'b1;
        load_prog(16'd33, D_EQ_A, 16'd50, 16'hFC10);
        dwait = 1000;
        restart();
        wait_dreq("t5");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5 dmem_req", bus.dmem_req, 0);
        chk("t5 imem_req", bus.imem_req, 0);
        chk("t5 pc", 32'(bus.pc), 0);
        load_prog(PROBE, PROBE, PROBE, PROBE);
        dwait = 0;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5 refetch addr", 32'(bus.imem_addr), 0);
        wait_probe("t5");
        chk("t5 D", 32'(bus.alu_x), 0);
        chk("t5 A", 32'(bus.alu_y), 0);

        // pc wraps from the top of the address space to 0
        reset = 1'b1;
        load_prog(16'h7FFF, 16'hEA87, PROBE, PROBE);
        rom[255] = 16'h0005;
        restart();
        wait_retires(2, "wrap");
        chk("wrap pc top", 32'(bus.pc), 32'h7FFF);
        wait_retires(3, "wrap");
        chk("wrap pc zero", 32'(bus.pc), 0);
        chk("wrap fetch addr", 32'(bus.imem_addr), 0);

`ifdef HACK_CTRL_TRAP_EN
        reset = 1'b1;
        load_prog(16'h8000, PROBE, PROBE, PROBE);
        restart();
        repeat (10) @(negedge clk);
        chk("trap flag", bus.trap, 1);
        chk("trap no retire", ret_cnt, 0);
        chk("trap no fetch", bus.imem_req, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
